// File: rtl/seg7_bcd_disp.sv
// Binary-to-seven-segment display driver: serial double-dabble conversion,
// optional sign digit, leading-zero blanking, overflow dashes and a blink mode.
module seg7_bcd_disp #(
    parameter int NDIG      = 4,
    parameter int BIN_W     = 12,
    parameter int SIGNED    = 1,
    parameter int LZB       = 1,
    parameter int BLINK_DIV = 22_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic [BIN_W-1:0]    value,
    input  logic                blank_req,
    output logic [8*NDIG-1:0]   hex,
    output logic                busy,
    output logic                overflow
);

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 8'hC0;
            4'd1:    glyph = 8'hF9;
            4'd2:    glyph = 8'hA4;
            4'd3:    glyph = 8'hB0;
            4'd4:    glyph = 8'h99;
            4'd5:    glyph = 8'h92;
            4'd6:    glyph = 8'h82;
            4'd7:    glyph = 8'hF8;
            4'd8:    glyph = 8'h80;
            4'd9:    glyph = 8'h90;
            default: glyph = 8'hFF;
        endcase
    endfunction

    localparam int ND    = (SIGNED != 0) ? NDIG - 1 : NDIG;
    localparam logic [31:0] MAXV = 32'(pow10(ND) - 1);
    // ceil(BIN_W/3) BCD digits always hold 2^BIN_W-1; widen to NDIG so every digit index exists
    localparam int NB    = (BIN_W + 2) / 3;
    localparam int NBA   = (NB > NDIG) ? NB : NDIG;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BL_W  = $clog2(BLINK_DIV);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);
    localparam logic [BL_W-1:0] BL_HALF = BL_W'(BLINK_DIV / 2);
    localparam logic [7:0] DASH  = 8'hBF;

    typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

    state_t                   state, state_next;
    logic [BIN_W-1:0]         mag, mag_in, shreg, shreg_next;
    logic                     neg, value_neg;
    logic [NBA-1:0][3:0]      bcd, bcd_next, adj;
    logic [CNT_W-1:0]         bitcnt;
    logic [8*NDIG-1:0]        disp, disp_fmt;
    logic                     ovf_fmt, seen;
    logic [BL_W-1:0]          blink_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE:    if (load) state_next = CONV;
            CONV: begin
                busy = 1'b1;
                if (bitcnt == CNT_W'(BIN_W - 1)) state_next = LATCH;
            end
            LATCH: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The most negative input negates to itself, which read as unsigned is exactly 2^(BIN_W-1)
    always_comb begin
        value_neg = (SIGNED != 0) && value[BIN_W-1];
        mag_in    = value_neg ? (BIN_W'(0) - value) : value;
    end

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NBA; i++) begin
            if (adj[i] >= 4'd5) adj[i] = adj[i] + 4'd3;
        end
        {bcd_next, shreg_next} = {adj, shreg} << 1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mag      <= '0;
            neg      <= 1'b0;
            shreg    <= '0;
            bcd      <= '0;
            bitcnt   <= '0;
            disp     <= '1;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (load) begin
                    mag    <= mag_in;
                    neg    <= value_neg;
                    shreg  <= mag_in;
                    bcd    <= '0;
                    bitcnt <= '0;
                end
                CONV: begin
                    bcd    <= bcd_next;
                    shreg  <= shreg_next;
                    bitcnt <= bitcnt + CNT_W'(1);
                end
                LATCH: begin
                    disp     <= disp_fmt;
                    overflow <= ovf_fmt;
                end
                default: ;
            endcase
        end
    end

    // Scan from the top digit down so leading-zero blanking knows when the first nonzero appeared
    always_comb begin
        disp_fmt = '1;
        ovf_fmt  = 32'(mag) > MAXV;
        seen     = 1'b0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            if (ovf_fmt) begin
                disp_fmt[8*k +: 8] = DASH;
            end else if (k < ND) begin
                if (bcd[k] != 4'd0 || k == 0 || LZB == 0) seen = 1'b1;
                if (seen) disp_fmt[8*k +: 8] = glyph(bcd[k]);
            end else if (neg && mag != '0) begin
                disp_fmt[8*k +: 8] = DASH;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                blink_cnt <= '0;
        else if (blink_cnt == BL_LAST) blink_cnt <= '0;
        else                         blink_cnt <= blink_cnt + BL_W'(1);
    end

    always_comb begin
        if (!reset_n)       hex = '1;
        else if (blank_req) hex = (blink_cnt < BL_HALF) ? {NDIG{DASH}} : '1;
        else                hex = disp;
    end

endmodule

// File: tb/tb_seg7_bcd_disp.sv
// Directed bench for seg7_bcd_disp: default 4-digit signed instance with a short
// blink period, plus a 6-digit unsigned 20-bit instance without blanking.
module tb_seg7_bcd_disp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load, blank_req;
    logic [11:0] value;
    logic [31:0] hex;
    logic        busy, overflow;

    logic        load6;
    logic [19:0] value6;
    logic [47:0] hex6;
    logic        busy6, overflow6;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_hex;
    int          mcnt;

    seg7_bcd_disp #(.BLINK_DIV(8)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .value(value),
        .blank_req(blank_req), .hex(hex), .busy(busy), .overflow(overflow)
    );

    seg7_bcd_disp #(.NDIG(6), .BIN_W(20), .SIGNED(0), .LZB(0), .BLINK_DIV(8)) dut6 (
        .clk(clk), .reset_n(reset_n), .load(load6), .value(value6),
        .blank_req(blank_req), .hex(hex6), .busy(busy6), .overflow(overflow6)
    );

    always #5 clk = ~clk;

    // Reference blink phase, restarted by reset like the design's counter
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)      mcnt <= 0;
        else if (mcnt == 7) mcnt <= 0;
        else               mcnt <= mcnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] v);
        @(negedge clk);
        load  = 1'b1;
        value = v;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic runConversion(input string tag, input logic [11:0] v,
                                 input logic [31:0] exp_hex, input logic exp_ovf);
        applyStimulus(v);
        checkOutput({tag, "_busy_rise"}, 64'(busy), 64'(1'b1));
        repeat (12) @(negedge clk);
        checkOutput({tag, "_busy_hold"}, 64'(busy), 64'(1'b1));
        checkOutput({tag, "_hex_hold"}, 64'(hex), 64'(last_hex));
        @(negedge clk);
        checkOutput({tag, "_busy_fall"}, 64'(busy), 64'(1'b0));
        checkOutput({tag, "_hex"}, 64'(hex), 64'(exp_hex));
        checkOutput({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
        last_hex = exp_hex;
    endtask

    initial begin
        reset_n   = 1'b0;
        load      = 1'b0;
        load6     = 1'b0;
        value     = '0;
        value6    = '0;
        blank_req = 1'b1;
        last_hex  = 32'hFFFF_FFFF;
        #12;
        checkOutput("rst_hex_blankreq", 64'(hex), 64'(32'hFFFF_FFFF));
        blank_req = 1'b0;
        #1;
        checkOutput("rst_hex", 64'(hex), 64'(32'hFFFF_FFFF));
        checkOutput("rst_busy", 64'(busy), 64'(1'b0));
        checkOutput("rst_ovf", 64'(overflow), 64'(1'b0));
        checkOutput("rst_hex6", 64'(hex6), 64'(48'hFFFF_FFFF_FFFF));
        @(negedge clk);
        reset_n = 1'b1;

        runConversion("v123",  12'd123,  32'hFFF9_A4B0, 1'b0);
        runConversion("vm5",   12'hFFB,  32'hBFFF_FF92, 1'b0);
        runConversion("v0",    12'd0,    32'hFFFF_FFC0, 1'b0);
        runConversion("v1000", 12'd1000, 32'hBFBF_BFBF, 1'b1);
        runConversion("vm2048",12'h800,  32'hBFBF_BFBF, 1'b1);
        runConversion("v999",  12'd999,  32'hFF90_9090, 1'b0);
        runConversion("v105",  12'd105,  32'hFFF9_C092, 1'b0);
        runConversion("vm120", 12'hF88,  32'hBFF9_A4C0, 1'b0);

        // A load arriving mid-conversion must be dropped, not restart or queue
        applyStimulus(12'd42);
        repeat (2) @(negedge clk);
        load  = 1'b1;
        value = 12'd777;
        @(negedge clk);
        load  = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("ign_busy_fall", 64'(busy), 64'(1'b0));
        checkOutput("ign_hex", 64'(hex), 64'(32'hFFFF_99A4));
        repeat (4) @(negedge clk);
        checkOutput("ign_no_queue", 64'(busy), 64'(1'b0));

        applyStimulus(12'd321);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_hex", 64'(hex), 64'(32'hFFFF_FFFF));
        checkOutput("abort_busy", 64'(busy), 64'(1'b0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_kept_clear", 64'(hex), 64'(32'hFFFF_FFFF));
        last_hex = 32'hFFFF_FFFF;
        runConversion("v7_after_rst", 12'd7, 32'hFFFF_FFF8, 1'b0);

        blank_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checkOutput($sformatf("blink_%0d", i), 64'(hex),
                        64'((mcnt < 4) ? 32'hBFBF_BFBF : 32'hFFFF_FFFF));
            @(negedge clk);
        end
        blank_req = 1'b0;
        #1;
        checkOutput("blink_restore", 64'(hex), 64'(32'hFFFF_FFF8));

        @(negedge clk);
        load6  = 1'b1;
        value6 = 20'd98765;
        @(negedge clk);
        load6  = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("w6_busy_hold", 64'(busy6), 64'(1'b1));
        checkOutput("w6_hex_hold", 64'(hex6), 64'(48'hFFFF_FFFF_FFFF));
        @(negedge clk);
        checkOutput("w6_busy_fall", 64'(busy6), 64'(1'b0));
        checkOutput("w6_hex", 64'(hex6), 64'(48'hC090_80F8_8292));
        checkOutput("w6_ovf", 64'(overflow6), 64'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
